// File: rtl/unidad_de_riesgos_pkg.sv
// unidad_de_riesgos_pkg: shared types and constants for the hazard unit and its ID/EX register
package unidad_de_riesgos_pkg;
    localparam int REG_W = 4;
    typedef enum logic [1:0] {LIBRE = 2'd0, ESPERA = 2'd1, ERROR = 2'd2} estado_t;
    typedef struct packed {
        logic [REG_W-1:0] rp;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rg;
        logic [1:0]       sel_a;
        logic [1:0]       sel_b;
        logic             prohib;
        logic             lee_mem;
    } campos_t;
    localparam campos_t BURBUJA = '{rp: '0, rs: '0, rg: '0, sel_a: '0, sel_b: '0, prohib: 1'b1, lee_mem: 1'b0};
endpackage

// File: rtl/unidad_de_riesgos_if.sv
// unidad_de_riesgos_if: ID-side operand fields, ID/EX outputs and stall/freeze controls
interface unidad_de_riesgos_if;
    import unidad_de_riesgos_pkg::*;
    logic [REG_W-1:0] RP_id, RS_id, RG_id;
    logic [1:0]       SelOp_A_id, SelOp_B_id;
    logic             usa_rp_id, usa_rs_id, prohib_id, lee_mem_id;
    logic             salto_tomado, lee_mem_mem, mem_listo;
    logic [REG_W-1:0] RP_exe, RS_exe, RG_exe;
    logic [1:0]       SelOp_A_exe, SelOp_B_exe;
    logic             prohib_exe, lee_mem_exe;
    logic             parar_if_id, congelar, error_mem;
    modport master (
        output RP_id, RS_id, RG_id, SelOp_A_id, SelOp_B_id, usa_rp_id, usa_rs_id,
               prohib_id, lee_mem_id, salto_tomado, lee_mem_mem, mem_listo,
        input  RP_exe, RS_exe, RG_exe, SelOp_A_exe, SelOp_B_exe, prohib_exe, lee_mem_exe,
               parar_if_id, congelar, error_mem
    );
    modport slave (
        input  RP_id, RS_id, RG_id, SelOp_A_id, SelOp_B_id, usa_rp_id, usa_rs_id,
               prohib_id, lee_mem_id, salto_tomado, lee_mem_mem, mem_listo,
        output RP_exe, RS_exe, RG_exe, SelOp_A_exe, SelOp_B_exe, prohib_exe, lee_mem_exe,
               parar_if_id, congelar, error_mem
    );
endinterface

// File: rtl/unidad_de_riesgos_registro_id_exe.sv
// registro_id_exe: ID/EX pipeline register with hold and bubble insertion
module registro_id_exe
    import unidad_de_riesgos_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    mantener,
    input  logic    burbuja,
    input  campos_t d,
    output campos_t q
);
    always_ff @(posedge clk) begin
        if (!rst)
            q <= BURBUJA;
        else if (!mantener)
            q <= burbuja ? BURBUJA : d;
    end
endmodule

// File: rtl/unidad_de_riesgos.sv
// unidad_de_riesgos: load-use/flush hazard control, memory-wait freeze FSM and ID/EX register
// Optional statistics counters enabled with RIESGOS_CONTADOR_EN.
module unidad_de_riesgos
    import unidad_de_riesgos_pkg::*;
#(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 16
) (
    input logic clk,
    input logic rst,
    unidad_de_riesgos_if.slave bus
`ifdef RIESGOS_CONTADOR_EN
    ,
    output logic [CNT_W-1:0] cnt_burbujas,
    output logic [CNT_W-1:0] cnt_espera
`endif
);
    localparam int WW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WW-1:0] LIMITE = WW'(TIMEOUT - 1);

    estado_t       estado, estado_sig;
    logic [WW-1:0] espera;
    campos_t       d, q;
    logic          riesgo, congelar, burbuja;

    assign d = '{rp: bus.RP_id, rs: bus.RS_id, rg: bus.RG_id, sel_a: bus.SelOp_A_id,
                 sel_b: bus.SelOp_B_id, prohib: bus.prohib_id, lee_mem: bus.lee_mem_id};
    assign riesgo = q.lee_mem & ~q.prohib &
                    ((bus.usa_rp_id & (q.rg == bus.RP_id)) | (bus.usa_rs_id & (q.rg == bus.RS_id)));
    assign burbuja = bus.salto_tomado | riesgo;

    // a taken branch discards the ID instruction, so it must not also stall IF/ID
    assign bus.congelar    = rst & congelar;
    assign bus.parar_if_id = rst & (congelar | (~bus.salto_tomado & riesgo));
    assign bus.error_mem   = (estado == ERROR);

    registro_id_exe u_registro (
        .clk      (clk),
        .rst      (rst),
        .mantener (congelar),
        .burbuja  (burbuja),
        .d        (d),
        .q        (q)
    );

    assign bus.RP_exe      = q.rp;
    assign bus.RS_exe      = q.rs;
    assign bus.RG_exe      = q.rg;
    assign bus.SelOp_A_exe = q.sel_a;
    assign bus.SelOp_B_exe = q.sel_b;
    assign bus.prohib_exe  = q.prohib;
    assign bus.lee_mem_exe = q.lee_mem;

    always_ff @(posedge clk) begin
        estado <= !rst ? LIBRE : estado_sig;
        espera <= (!rst || estado != ESPERA) ? '0 : espera + 1'b1;
    end

    always_comb begin
        estado_sig = estado;
        congelar   = 1'b0;
        case (estado)
            LIBRE: begin
                congelar   = bus.lee_mem_mem & ~bus.mem_listo;
                estado_sig = congelar ? ESPERA : LIBRE;
            end
            ESPERA: begin
                congelar   = ~bus.mem_listo;
                estado_sig = bus.mem_listo ? LIBRE : (espera == LIMITE) ? ERROR : ESPERA;
            end
            default: begin
                congelar   = 1'b1;
                estado_sig = ERROR;
            end
        endcase
    end

`ifdef RIESGOS_CONTADOR_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_burbujas <= '0;
            cnt_espera   <= '0;
        end else begin
            if (~congelar & ~bus.salto_tomado & riesgo & ~&cnt_burbujas)
                cnt_burbujas <= cnt_burbujas + 1'b1;
            if (congelar & ~&cnt_espera)
                cnt_espera <= cnt_espera + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_unidad_de_riesgos.sv
// tb_unidad_de_riesgos: scoreboard bench comparing the hazard unit against a cycle model
module tb_unidad_de_riesgos;
    typedef struct packed {
        logic       rst_n;
        logic [3:0] rp, rs, rg;
        logic [1:0] sa, sb;
        logic       urp, urs, pr, lm, salto, lmm, listo;
    } stim_t;
    typedef struct packed {
        logic [3:0]  rp, rs, rg;
        logic [1:0]  sa, sb;
        logic        pr, lm, err;
        logic [15:0] nb, ne;
    } esp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [15:0] cnt_b, cnt_e;
    int checks = 0;
    int fails = 0;
    esp_t cola[$];
    esp_t m;
    int m_est = 0;
    int m_wcnt = 0;
    stim_t s;

    unidad_de_riesgos_if bus();

    unidad_de_riesgos #(.TIMEOUT(64), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef RIESGOS_CONTADOR_EN
        ,
        .cnt_burbujas (cnt_b),
        .cnt_espera   (cnt_e)
`endif
    );

    always #5 clk = ~clk;

    task automatic chequear(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    task automatic ciclo(input stim_t st);
        esp_t e;
        logic hz, cong, par;
        int est_n;
        @(negedge clk);
        rst = st.rst_n;
        bus.RP_id = st.rp; bus.RS_id = st.rs; bus.RG_id = st.rg;
        bus.SelOp_A_id = st.sa; bus.SelOp_B_id = st.sb;
        bus.usa_rp_id = st.urp; bus.usa_rs_id = st.urs;
        bus.prohib_id = st.pr; bus.lee_mem_id = st.lm;
        bus.salto_tomado = st.salto; bus.lee_mem_mem = st.lmm; bus.mem_listo = st.listo;
        #1;
        hz = m.lm & ~m.pr & ((st.urp & (m.rg == st.rp)) | (st.urs & (m.rg == st.rs)));
        cong = !st.rst_n ? 1'b0 : (m_est == 0) ? (st.lmm & ~st.listo) : (m_est == 1) ? ~st.listo : 1'b1;
        par = st.rst_n & (cong | (~st.salto & hz));
        chequear("congelar", {31'd0, bus.congelar}, {31'd0, cong});
        chequear("parar_if_id", {31'd0, bus.parar_if_id}, {31'd0, par});
        if (!st.rst_n) begin
            m = '0;
            m.pr = 1'b1;
            m_est = 0;
            m_wcnt = 0;
        end else begin
            if (!cong && (st.salto || hz)) begin
                m.rp = 0; m.rs = 0; m.rg = 0; m.sa = 0; m.sb = 0; m.pr = 1'b1; m.lm = 1'b0;
            end else if (!cong) begin
                m.rp = st.rp; m.rs = st.rs; m.rg = st.rg; m.sa = st.sa; m.sb = st.sb;
                m.pr = st.pr; m.lm = st.lm;
            end
            if (!cong && !st.salto && hz && m.nb != 16'hFFFF) m.nb++;
            if (cong && m.ne != 16'hFFFF) m.ne++;
            est_n = (m_est == 0) ? (cong ? 1 : 0) :
                    (m_est == 1) ? (st.listo ? 0 : (m_wcnt == 63) ? 2 : 1) : 2;
            m_wcnt = (m_est == 1) ? m_wcnt + 1 : 0;
            m_est = est_n;
        end
        m.err = (m_est == 2);
        cola.push_back(m);
        @(posedge clk);
        #1;
        e = cola.pop_front();
        chequear("RP_exe", {28'd0, bus.RP_exe}, {28'd0, e.rp});
        chequear("RS_exe", {28'd0, bus.RS_exe}, {28'd0, e.rs});
        chequear("RG_exe", {28'd0, bus.RG_exe}, {28'd0, e.rg});
        chequear("SelOp_A_exe", {30'd0, bus.SelOp_A_exe}, {30'd0, e.sa});
        chequear("SelOp_B_exe", {30'd0, bus.SelOp_B_exe}, {30'd0, e.sb});
        chequear("prohib_exe", {31'd0, bus.prohib_exe}, {31'd0, e.pr});
        chequear("lee_mem_exe", {31'd0, bus.lee_mem_exe}, {31'd0, e.lm});
        chequear("error_mem", {31'd0, bus.error_mem}, {31'd0, e.err});
`ifdef RIESGOS_CONTADOR_EN
        chequear("cnt_burbujas", {16'd0, cnt_b}, {16'd0, e.nb});
        chequear("cnt_espera", {16'd0, cnt_e}, {16'd0, e.ne});
`endif
    endtask

    task automatic neutro();
        s = '0;
        s.rst_n = 1'b1;
        s.pr = 1'b1;
    endtask

    task automatic reinicio();
        neutro();
        s.rst_n = 1'b0;
        ciclo(s);
        chequear("reset_prohib", {31'd0, bus.prohib_exe}, 32'd1);
        chequear("reset_error", {31'd0, bus.error_mem}, 32'd0);
    endtask

    task automatic carga_y_uso(input logic [3:0] r, input logic usa, input logic salto);
        neutro();
        s.rg = r; s.lm = 1'b1; s.pr = 1'b0;
        ciclo(s);
        neutro();
        s.rp = r; s.urp = usa; s.rg = 4'd9; s.pr = 1'b0; s.sa = 2'd2; s.salto = salto;
        ciclo(s);
        s.salto = 1'b0;
        ciclo(s);
    endtask

    task automatic espera_mem(input int n);
        neutro();
        s.lmm = 1'b1;
        for (int i = 0; i < n; i++) ciclo(s);
        s.listo = 1'b1;
        ciclo(s);
        neutro();
        ciclo(s);
    endtask

    initial begin
        m = '0;
        m.pr = 1'b1;
        reinicio();
        reinicio();
        neutro();
        s.rg = 4'd3; s.lm = 1'b1; s.pr = 1'b0;
        ciclo(s);
        neutro();
        s.rp = 4'd3; s.urp = 1'b1; s.rg = 4'd6; s.pr = 1'b0;
        ciclo(s);
        chequear("stall_bubble_prohib", {31'd0, bus.prohib_exe}, 32'd1);
        chequear("stall_bubble_rg", {28'd0, bus.RG_exe}, 32'd0);
        ciclo(s);
        chequear("stall_consumer_rp", {28'd0, bus.RP_exe}, 32'd3);
        carga_y_uso(4'd5, 1'b0, 1'b0);
        carga_y_uso(4'd7, 1'b1, 1'b1);
        carga_y_uso(4'd2, 1'b1, 1'b0);
        neutro();
        s.rp = 4'd4; s.rg = 4'd11; s.pr = 1'b0;
        ciclo(s);
        espera_mem(3);
        chequear("wait_exe_held", {28'd0, bus.RG_exe}, 32'd0);
        neutro();
        s.lmm = 1'b1; s.listo = 1'b1;
        ciclo(s);
        for (int i = 0; i < 300; i++) begin
            s.rst_n = ($urandom_range(0, 40) != 0);
            s.rp = 4'($urandom_range(0, 3)); s.rs = 4'($urandom_range(0, 3));
            s.rg = 4'($urandom_range(0, 3));
            s.sa = 2'($urandom); s.sb = 2'($urandom);
            s.urp = 1'($urandom); s.urs = 1'($urandom);
            s.pr = ($urandom_range(0, 3) == 0); s.lm = 1'($urandom);
            s.salto = ($urandom_range(0, 3) == 0);
            s.lmm = 1'($urandom); s.listo = 1'($urandom);
            ciclo(s);
        end
        reinicio();
        neutro();
        s.lmm = 1'b1;
        for (int i = 0; i < 60; i++) ciclo(s);
        chequear("no_early_error", {31'd0, bus.error_mem}, 32'd0);
        for (int i = 0; i < 10; i++) ciclo(s);
        chequear("timeout_error", {31'd0, bus.error_mem}, 32'd1);
        s.listo = 1'b1;
        for (int i = 0; i < 3; i++) ciclo(s);
        chequear("error_sticky", {31'd0, bus.error_mem}, 32'd1);
        reinicio();
        neutro();
        ciclo(s);
        carga_y_uso(4'd3, 1'b1, 1'b0);
        carga_y_uso(4'd8, 1'b1, 1'b0);
        espera_mem(3);
`ifdef RIESGOS_CONTADOR_EN
        chequear("total_burbujas", {16'd0, cnt_b}, 32'd2);
        chequear("total_espera", {16'd0, cnt_e}, 32'd3);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
